// File: rtl/prim_sync_reqack_src_if.sv
// Handshake bundle for the source end of a 4-phase req/ack CDC link.
// The master view belongs to the source block; the slave view belongs to its environment.
interface prim_sync_reqack_src_if #(
  parameter int unsigned Width = 16
);
  logic             src_valid_i;
  logic             src_ready_o;
  logic [Width-1:0] src_data_i;
  logic             cdc_req_o;
  logic [Width-1:0] cdc_data_o;
  logic             cdc_ack_i;
  logic             busy_o;

  modport master (
    input  src_valid_i, src_data_i, cdc_ack_i,
    output src_ready_o, cdc_req_o, cdc_data_o, busy_o
  );

  modport slave (
    output src_valid_i, src_data_i, cdc_ack_i,
    input  src_ready_o, cdc_req_o, cdc_data_o, busy_o
  );
endinterface

// File: rtl/prim_sync_reqack_src.sv
// Source end of a 4-phase req/ack clock-domain crossing: registers one word,
// raises a glitch-free request and waits for the synchronized acknowledge to complete.
module prim_sync_reqack_src #(
  parameter int unsigned Width      = 16,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  prim_sync_reqack_src_if.master bus
);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    ReqHi = 2'd1,
    ReqLo = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [Width-1:0] data_q, data_d;

  (* ASYNC_REG = "TRUE" *) logic ack_s1_q;
  (* ASYNC_REG = "TRUE" *) logic ack_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_s1_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_s1_q <= bus.cdc_ack_i;
      ack_q    <= ack_s1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      req_q   <= 1'b0;
      data_q  <= {Width{ResetValue}};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  // A lingering ack blocks acceptance so a new request can never merge into a stale one.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    unique case (state_q)
      Idle: begin
        if (bus.src_valid_i && !ack_q) begin
          data_d  = bus.src_data_i;
          req_d   = 1'b1;
          state_d = ReqHi;
        end
      end
      ReqHi: begin
        if (ack_q) begin
          req_d   = 1'b0;
          state_d = ReqLo;
        end
      end
      ReqLo: begin
        if (!ack_q) begin
          state_d = Idle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = Idle;
      end
    endcase
  end

  assign bus.src_ready_o = (state_q == Idle) && !ack_q;
  assign bus.busy_o      = (state_q != Idle);
  assign bus.cdc_req_o   = req_q;
  assign bus.cdc_data_o  = data_q;

endmodule
